// File: rtl/drive_cmd_arbiter.sv
// Drive command arbiter: merges N prioritised, time-limited command
// sources into one valid/ready stream with an emergency-stop override.
module drive_cmd_arbiter #(
    parameter int NUM_SRC     = 3,
    parameter int CMD_W       = 3,
    parameter int SPEED_W     = 2,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int STOP_CMD    = 0,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1),
    parameter int SRC_W       = $clog2(NUM_SRC + 1)
) (
    input  logic                       clk_50,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*CMD_W-1:0]   src_cmd,
    input  logic [NUM_SRC*SPEED_W-1:0] src_speed,
    input  logic [NUM_SRC-1:0]         src_enable,
    input  logic                       estop,
    output logic [CMD_W-1:0]           out_cmd,
    output logic [SPEED_W-1:0]         out_speed,
    output logic [SRC_W-1:0]           out_src,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       active,
    output logic                       timeout_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CMD_W-1:0] STOP_V  = CMD_W'(STOP_CMD);
    localparam logic [SRC_W-1:0] NONE_V  = SRC_W'(NUM_SRC);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Per-source freshness and latched command state
    logic [CNT_W-1:0]   cnt_q   [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d   [NUM_SRC];
    logic [CMD_W-1:0]   cmd_q   [NUM_SRC];
    logic [CMD_W-1:0]   cmd_d   [NUM_SRC];
    logic [SPEED_W-1:0] speed_q [NUM_SRC];
    logic [SPEED_W-1:0] speed_d [NUM_SRC];
    logic [NUM_SRC-1:0] live;

    // Current selection
    logic [CMD_W-1:0]   sel_cmd;
    logic [SPEED_W-1:0] sel_speed;
    logic [SRC_W-1:0]   sel_src;
    logic               found;
    logic               expire_hit;

    // Output handshake state
    state_t             state_q, state_d;
    logic [CMD_W-1:0]   out_cmd_q, out_cmd_d;
    logic [SPEED_W-1:0] out_speed_q, out_speed_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic [CMD_W-1:0]   last_cmd_q, last_cmd_d;
    logic [SPEED_W-1:0] last_speed_q, last_speed_d;
    logic [SRC_W-1:0]   last_src_q, last_src_d;
    logic               tflag_q;

    // A source is live while its freshness counter is nonzero
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            live[i] = (cnt_q[i] != '0);
        end
    end

    // Capture on strobe (reload wins over expiry), otherwise count down
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_d[i]   = cnt_q[i];
            cmd_d[i]   = cmd_q[i];
            speed_d[i] = speed_q[i];
            if (src_valid[i]) begin
                cnt_d[i]   = RELOAD;
                cmd_d[i]   = src_cmd[i*CMD_W +: CMD_W];
                speed_d[i] = src_speed[i*SPEED_W +: SPEED_W];
            end else if (live[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    // Freshness counters and latched commands
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i]   <= '0;
                cmd_q[i]   <= '0;
                speed_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i]   <= cnt_d[i];
                cmd_q[i]   <= cmd_d[i];
                speed_q[i] <= speed_d[i];
            end
        end
    end

    // Fixed-priority pick of the lowest live, enabled source
    always_comb begin
        sel_cmd   = STOP_V;
        sel_speed = '0;
        sel_src   = NONE_V;
        found     = 1'b0;
        if (!estop) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && live[i] && src_enable[i]) begin
                    found     = 1'b1;
                    sel_cmd   = cmd_q[i];
                    sel_speed = speed_q[i];
                    sel_src   = SRC_W'(i);
                end
            end
        end
    end

    // Selected source is about to expire at the next edge
    always_comb begin
        expire_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_src == SRC_W'(i) && cnt_q[i] == CNT_ONE
                && !src_valid[i]) begin
                expire_hit = 1'b1;
            end
        end
    end

    // Timeout pulse lands in the cycle the selected source turns stale
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            tflag_q <= 1'b0;
        end else begin
            tflag_q <= expire_hit;
        end
    end

    // Output FSM: launch on selection change, hold until accepted
    always_comb begin
        state_d      = state_q;
        out_cmd_d    = out_cmd_q;
        out_speed_d  = out_speed_q;
        out_src_d    = out_src_q;
        last_cmd_d   = last_cmd_q;
        last_speed_d = last_speed_q;
        last_src_d   = last_src_q;
        unique case (state_q)
            IDLE: begin
                if ({sel_cmd, sel_speed, sel_src} !=
                    {last_cmd_q, last_speed_q, last_src_q}) begin
                    out_cmd_d   = sel_cmd;
                    out_speed_d = sel_speed;
                    out_src_d   = sel_src;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    last_cmd_d   = out_cmd_q;
                    last_speed_d = out_speed_q;
                    last_src_d   = out_src_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output FSM registers; reset discards any pending transfer
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            out_cmd_q    <= STOP_V;
            out_speed_q  <= '0;
            out_src_q    <= NONE_V;
            last_cmd_q   <= STOP_V;
            last_speed_q <= '0;
            last_src_q   <= NONE_V;
        end else begin
            state_q      <= state_d;
            out_cmd_q    <= out_cmd_d;
            out_speed_q  <= out_speed_d;
            out_src_q    <= out_src_d;
            last_cmd_q   <= last_cmd_d;
            last_speed_q <= last_speed_d;
            last_src_q   <= last_src_d;
        end
    end

    assign out_cmd      = out_cmd_q;
    assign out_speed    = out_speed_q;
    assign out_src      = out_src_q;
    assign out_valid    = (state_q == SEND);
    assign active       = (sel_src != NONE_V);
    assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Directed bench for drive_cmd_arbiter with a transfer scoreboard.
// Inputs change at posedge+2, outputs are sampled at negedge.
module tb_drive_cmd_arbiter;

    localparam int N    = 3;
    localparam int CW   = 3;
    localparam int SW   = 2;
    localparam int TO   = 8;
    localparam int SRCW = 2;

    logic              clk_50 = 1'b0;
    logic              reset;
    logic [N-1:0]      src_valid;
    logic [N*CW-1:0]   src_cmd;
    logic [N*SW-1:0]   src_speed;
    logic [N-1:0]      src_enable;
    logic              estop;
    logic [CW-1:0]     out_cmd;
    logic [SW-1:0]     out_speed;
    logic [SRCW-1:0]   out_src;
    logic              out_valid;
    logic              out_ready;
    logic              active;
    logic              timeout_flag;

    typedef logic [6:0] xfer_t;

    xfer_t sb[$];
    int    tests  = 0;
    int    fails  = 0;
    int    to_cnt = 0;
    int    to_exp = 0;
    int    tick   = 0;
    bit    ref0   = 1'b0;
    bit    ref2   = 1'b0;

    always #5 clk_50 = ~clk_50;

    drive_cmd_arbiter #(
        .NUM_SRC(N),
        .CMD_W(CW),
        .SPEED_W(SW),
        .TIMEOUT_CYC(TO),
        .STOP_CMD(0)
    ) dut (
        .clk_50(clk_50),
        .reset(reset),
        .src_valid(src_valid),
        .src_cmd(src_cmd),
        .src_speed(src_speed),
        .src_enable(src_enable),
        .estop(estop),
        .out_cmd(out_cmd),
        .out_speed(out_speed),
        .out_src(out_src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .active(active),
        .timeout_flag(timeout_flag)
    );

    function automatic xfer_t xf(input int c, input int s, input int src);
        return {3'(c), 2'(s), 2'(src)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int i, input int c, input int s);
        src_valid[i]          = 1'b1;
        src_cmd[i*CW +: CW]   = 3'(c);
        src_speed[i*SW +: SW] = 2'(s);
    endtask

    // One clock per iteration: periodic refreshes, negedge monitor,
    // then strobes are cleared just after the capturing edge.
    task automatic cyc(input int n);
        xfer_t got;
        xfer_t want;
        for (int k = 0; k < n; k++) begin
            if (ref0 && (tick % 4 == 2)) strobe(0, 2, 3);
            if (ref2 && (tick % 4 == 0)) strobe(2, 5, 2);
            @(negedge clk_50);
            if (timeout_flag) to_cnt++;
            if (out_valid && out_ready) begin
                got = {out_cmd, out_speed, out_src};
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL unexpected_xfer: observed %0h expected none",
                           got);
                end else begin
                    want = sb.pop_front();
                    check("xfer", 32'(got), 32'(want));
                end
            end
            @(posedge clk_50);
            #2;
            src_valid = '0;
            tick++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        src_valid  = '0;
        src_cmd    = '0;
        src_speed  = '0;
        src_enable = '1;
        estop      = 1'b0;
        out_ready  = 1'b1;

        // Reset values
        repeat (2) @(posedge clk_50);
        #2;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_out", 32'({out_cmd, out_speed, out_src}), 32'(xf(0, 0, 3)));
        check("rst_active", 32'(active), 0);
        check("rst_tflag", 32'(timeout_flag), 0);
        reset = 1'b0;
        cyc(3);
        check("idle_no_xfer", 32'(out_valid), 0);

        // Single source 2 strobe, 2-cycle latency, 1-cycle transfer
        sb.push_back(xf(5, 2, 2));
        strobe(2, 5, 2);
        ref2 = 1'b1;
        cyc(1);
        check("t1_active", 32'(active), 1);
        check("t1_lat1", 32'(out_valid), 0);
        cyc(1);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_out", 32'({out_cmd, out_speed, out_src}), 32'(xf(5, 2, 2)));
        cyc(1);
        check("t1_one_cycle", 32'(out_valid), 0);

        // Preemption by source 0, then its expiry hands back to source 2
        sb.push_back(xf(1, 1, 0));
        sb.push_back(xf(5, 2, 2));
        to_exp++;
        strobe(0, 1, 1);
        cyc(1);
        cyc(7);
        check("t2_tflag_early", 32'(timeout_flag), 0);
        check("t2_sent_src0", 32'(out_src), 0);
        cyc(1);
        check("t2_tflag", 32'(timeout_flag), 1);
        check("t2_active", 32'(active), 1);
        cyc(1);
        check("t2_tflag_once", 32'(timeout_flag), 0);
        cyc(3);
        check("t2_to_cnt", 32'(to_cnt), 32'(to_exp));

        // Backpressure: output held while source 1 keeps changing
        out_ready = 1'b0;
        sb.push_back(xf(3, 1, 1));
        strobe(1, 3, 1);
        cyc(3);
        check("t3_hold_a", 32'({out_valid, out_cmd}), 32'({1'b1, 3'd3}));
        strobe(1, 4, 1);
        cyc(3);
        check("t3_hold_b", 32'({out_valid, out_cmd}), 32'({1'b1, 3'd3}));
        strobe(1, 6, 1);
        cyc(4);
        check("t3_hold_c", 32'({out_cmd, out_speed, out_src}),
              32'(xf(3, 1, 1)));
        out_ready = 1'b1;
        sb.push_back(xf(6, 1, 1));
        cyc(4);
        check("t3_sent_6", 32'(out_cmd), 6);
        sb.push_back(xf(5, 2, 2));
        to_exp++;
        cyc(12);
        check("t3_to_cnt", 32'(to_cnt), 32'(to_exp));

        // Emergency stop overrides a live source 0
        sb.push_back(xf(2, 3, 0));
        strobe(0, 2, 3);
        ref0 = 1'b1;
        cyc(4);
        estop = 1'b1;
        sb.push_back(xf(0, 0, 3));
        #1;
        check("t4_estop_active", 32'(active), 0);
        cyc(4);
        check("t4_estop_out", 32'({out_cmd, out_speed, out_src}),
              32'(xf(0, 0, 3)));
        check("t4_estop_no_tflag", 32'(to_cnt), 32'(to_exp));
        estop = 1'b0;
        sb.push_back(xf(2, 3, 0));
        cyc(4);
        check("t4_release_active", 32'(active), 1);
        ref0 = 1'b0;
        sb.push_back(xf(5, 2, 2));
        to_exp++;
        cyc(12);
        check("t4_to_cnt", 32'(to_cnt), 32'(to_exp));

        // Refresh exactly when the counter reads 1
        sb.push_back(xf(7, 0, 1));
        strobe(1, 7, 0);
        cyc(1);
        cyc(7);
        check("t5_live_at_1", 32'(active), 1);
        strobe(1, 7, 0);
        cyc(1);
        check("t5_still_live", 32'({active, out_src}), 32'({1'b1, 2'd1}));
        check("t5_no_tflag", 32'(timeout_flag), 0);
        cyc(2);
        check("t5_to_cnt", 32'(to_cnt), 32'(to_exp));
        sb.push_back(xf(5, 2, 2));
        to_exp++;
        cyc(12);
        check("t5_to_cnt_end", 32'(to_cnt), 32'(to_exp));

        // Asynchronous reset during a pending transfer
        ref2 = 1'b0;
        out_ready = 1'b0;
        strobe(0, 3, 1);
        cyc(2);
        check("t6_pending", 32'({out_valid, out_cmd, out_speed, out_src}),
              32'({1'b1, xf(3, 1, 0)}));
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 0);
        check("t6_async_out", 32'({out_cmd, out_speed, out_src}),
              32'(xf(0, 0, 3)));
        check("t6_async_active", 32'({active, timeout_flag}), 0);
        cyc(2);
        reset = 1'b0;
        out_ready = 1'b1;
        cyc(12);
        check("t6_quiet", 32'({out_valid, active}), 0);
        check("sb_empty", 32'(sb.size()), 0);
        check("to_total", 32'(to_cnt), 32'(to_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/drive_cmd_arbiter.md
Name: drive_cmd_arbiter

Overview:
- Parametrised arbiter that merges drive commands from N control sources into one stream for the robot drive path and the UART JSON link.
- Typical sources: IR remote, camera direction classifier, mic-derived speed.
- Provides fixed priority, a per-source freshness timeout, an emergency-stop override, and a valid/ready handshake to the UART packetiser.
- Sits between the source decoders and json_to_uart_top / FSM, replacing ad-hoc direct wiring.

Parameters:
NUM_SRC, 3, number of command sources; index 0 is the highest priority.
CMD_W, 3, width of each drive command.
SPEED_W, 2, width of each speed field.
TIMEOUT_CYC, 50000000, cycles a source stays live after its last src_valid (1 s at 50 MHz).
STOP_CMD, 0, command value emitted on estop or when no source is live.
CNT_W, $clog2(TIMEOUT_CYC+1), freshness counter width (derived).
SRC_W, $clog2(NUM_SRC+1), width of the source index; value NUM_SRC means "none".

Ports:
clk_50  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
src_valid  in  NUM_SRC  per-source one-cycle strobe: a new command is present.
src_cmd  in  NUM_SRC*CMD_W  packed commands; source i occupies [i*CMD_W +: CMD_W].
src_speed  in  NUM_SRC*SPEED_W  packed speeds, same packing as src_cmd.
src_enable  in  NUM_SRC  level mask; a disabled source is never selected.
estop  in  1  level; forces STOP_CMD with speed 0.
out_cmd  out  CMD_W  command offered to the consumer.
out_speed  out  SPEED_W  speed offered to the consumer.
out_src  out  SRC_W  index of the source that owns out_cmd; NUM_SRC when none.
out_valid  out  1  transfer request.
out_ready  in  1  consumer accept.
active  out  1  the currently selected source is live and enabled, and estop is low.
timeout_flag  out  1  one-cycle pulse when the selected source goes stale.

Behaviour:
- Reset:
  - all freshness counters cleared to 0 (all sources stale);
  - latched cmd/speed cleared to 0;
  - out_valid=0, out_cmd=STOP_CMD, out_speed=0, out_src=NUM_SRC;
  - active=0, timeout_flag=0;
  - last_sent register set to {STOP_CMD, 0, NUM_SRC}; FSM in IDLE.
  - Reset asserted mid-transfer drops out_valid immediately (asynchronous); the pending transfer is discarded.
- Capture:
  - On src_valid[i] at edge t, register cmd/speed i and reload counter i to TIMEOUT_CYC at that edge.
  - Otherwise, a nonzero counter decrements by 1 each cycle.
  - Source i is live while its counter is nonzero. It goes stale exactly TIMEOUT_CYC cycles after the last strobe.
  - src_valid on a counter-at-1 cycle: reload wins; the source does not go stale.
  - Disabled sources still capture and count, so re-enabling a recently active source selects it immediately.
- Selection (combinational from registered state):
  - sel = lowest index i with live[i] & src_enable[i].
  - If estop or no such i: sel_cmd=STOP_CMD, sel_speed=0, sel_src=NUM_SRC.
  - Otherwise: sel = latched {cmd[i], speed[i], i}.
  - active = (sel_src != NUM_SRC).
- timeout_flag pulses when the previous cycle's sel_src=i (not NUM_SRC) and live[i] falls this cycle due to counter expiry. It does not pulse on estop, on disable, or on preemption.
- Output FSM, IDLE:
  - If {sel_cmd, sel_speed, sel_src} != last_sent: on the next edge load out_* with sel, set out_valid=1, go to SEND.
  - Latency from src_valid edge to out_valid high is 2 cycles.
- Output FSM, SEND:
  - out_* are held stable while out_valid=1, regardless of selection changes.
  - On out_valid & out_ready: last_sent <= out_*, out_valid <= 0, return to IDLE.
  - If the selection changed meanwhile, IDLE starts a new transfer on the following edge (1 idle cycle minimum between transfers).
- Identical repeated commands from the same source refresh freshness only; they produce no transfer.
- out_ready while IDLE is ignored.
- Priority preemption: a higher-priority source becoming live changes the selection the same cycle it latches, subject to the SEND hold.

Test Plan:
- Params NUM_SRC=3, TIMEOUT_CYC=8, all enabled. Pulse src_valid[2] with cmd=5, speed=2; out_ready tied to 1 -> out_valid high 2 cycles later with {5,2,src 2} for exactly 1 cycle.
- Source 2 live with cmd=5. Pulse src_valid[0] with cmd=1 -> transfer {1,x,src 0}. No further src_valid[0] -> 8 cycles later timeout_flag pulses once and a transfer {5,2,src 2} follows (source 2 refreshed every 4 cycles).
- out_ready held 0 for 10 cycles while source 1 changes cmd 3->4->6 -> out_* stay at the first value throughout. After out_ready=1, the next transfer carries 6.
- Assert estop while source 0 is live -> transfer {STOP_CMD,0,src 3}, active=0, no timeout_flag. Release estop -> transfer of source 0's latched command.
- Pulse src_valid[1] on the cycle its counter reads 1 -> no stale, no timeout_flag, no transfer.
- Assert reset while out_valid=1 -> out_valid falls asynchronously and all outputs take their reset values. After release, with no sources live, no transfer occurs.
